fw_header_parser: RTL and testbench

- Upstream stage of the firewall Bloom-filter lookup.
- Consumes an IPv4 packet as a stream of 32-bit big-endian words, starting at the first word of the IP header.
- Extracts the 5-tuple and presents it on a valid/ready port as the 72-bit `{src_ip, dst_ip, protocol}` word plus source and destination ports. This is exactly the input format the Bloom-filter/hash stage expects.
- Discards malformed headers and counts them.

---
 rtl/fw_pkg.sv | 21 ++
 rtl/fw_tuple_buf.sv | 33 +++
 rtl/fw_header_parser.sv | 146 ++++++++++++++
 tb/tb_fw_header_parser.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fw_pkg.sv
// Shared types and constants for the firewall header parser and its output buffer.
package fw_pkg;
  localparam logic [3:0] IPV4_VER  = 4'd4;
  localparam logic [3:0] IHL_MIN   = 4'd5;
  localparam logic [7:0] PROTO_TCP = 8'd6;
  localparam logic [7:0] PROTO_UDP = 8'd17;

  typedef enum logic [1:0] {P_IDLE, P_HDR, P_L4, P_DRAIN} fw_state_e;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  protocol;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } fw_tuple_t;

  function automatic logic is_l4(input logic [7:0] proto);
    return (proto == PROTO_TCP) || (proto == PROTO_UDP);
  endfunction
endpackage

// File: rtl/fw_tuple_buf.sv
// One-entry output register for the 5-tuple; stall_o tells the parser a new load must wait.
module fw_tuple_buf
  import fw_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load_i,
  input  fw_tuple_t tuple_i,
  input  logic      m_ready_i,
  output logic      m_valid_o,
  output fw_tuple_t tuple_o,
  output logic      stall_o
);
  logic      valid_q;
  fw_tuple_t data_q;

  // A load wins over a pop so a simultaneous pop/reload keeps valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= tuple_i;
    end else if (valid_q && m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid_o = valid_q;
  assign tuple_o   = data_q;
  assign stall_o   = valid_q && !m_ready_i;
endmodule

// File: rtl/fw_header_parser.sv
// IPv4 header parser: extracts the 5-tuple from a 32-bit word stream and counts malformed packets.
module fw_header_parser
  import fw_pkg::*;
#(
  parameter int ERR_CNT_W   = 16,
  parameter bit EMIT_NON_L4 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [71:0]          m_ip_protocol,
  output logic [15:0]          m_src_port,
  output logic [15:0]          m_dst_port,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ERR_CNT_W-1:0] err_count
);
  fw_state_e      state_q, state_d;
  logic [3:0]     widx_q, widx_d, ihl_q, ihl_d;
  logic           frag_q, frag_d, errf_q, errf_d;
  logic [7:0]     proto_q, proto_d;
  logic [31:0]    src_q, src_d, dst_q, dst_d;
  logic [ERR_CNT_W-1:0] err_q;
  logic           err_inc, accept, load, stall, final_hdr, has_l4, emit_cand, hdr_bad;
  fw_tuple_t      tuple, buf_q;

  // Emission depends only on registered state, so the stall path stays short.
  assign final_hdr = (widx_q == ihl_q - 4'd1);
  assign has_l4    = is_l4(proto_q) && !frag_q;
  assign emit_cand = (state_q == P_L4) ||
                     ((state_q == P_HDR) && final_hdr && !has_l4 && EMIT_NON_L4);
  assign s_ready   = !(s_valid && emit_cand && stall);
  assign accept    = s_valid && s_ready;
  assign load      = accept && emit_cand;
  assign hdr_bad   = (s_data[31:28] != IPV4_VER) || (s_data[27:24] < IHL_MIN);

  always_comb begin
    tuple          = '0;
    tuple.src_ip   = src_q;
    tuple.dst_ip   = (widx_q == 4'd4) ? s_data : dst_q;
    tuple.protocol = proto_q;
    if (state_q == P_L4) begin
      tuple.src_port = s_data[31:16];
      tuple.dst_port = s_data[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    ihl_d   = ihl_q;
    frag_d  = frag_q;
    errf_d  = errf_q;
    proto_d = proto_q;
    src_d   = src_q;
    dst_d   = dst_q;
    err_inc = 1'b0;
    if (accept) begin
      widx_d = s_last ? 4'd0 : widx_q + 4'd1;
      case (state_q)
        P_IDLE: begin
          if (s_last) err_inc = 1'b1;
          else if (hdr_bad) begin
            state_d = P_DRAIN;
            errf_d  = 1'b1;
          end else begin
            ihl_d   = s_data[27:24];
            state_d = P_HDR;
          end
        end
        P_HDR: begin
          case (widx_q)
            4'd1:    frag_d  = (s_data[12:0] != 13'd0);
            4'd2:    proto_d = s_data[23:16];
            4'd3:    src_d   = s_data;
            4'd4:    dst_d   = s_data;
            default: ;
          endcase
          if (final_hdr) begin
            if (has_l4) begin
              // A TCP/UDP packet ending before its port word is short.
              err_inc = s_last;
              state_d = s_last ? P_IDLE : P_L4;
            end else begin
              state_d = s_last ? P_IDLE : P_DRAIN;
            end
          end else if (s_last) begin
            err_inc = 1'b1;
            state_d = P_IDLE;
          end
        end
        P_L4: state_d = s_last ? P_IDLE : P_DRAIN;
        default: begin
          if (s_last) begin
            err_inc = errf_q;
            errf_d  = 1'b0;
            state_d = P_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= P_IDLE;
      widx_q  <= '0;
      ihl_q   <= '0;
      frag_q  <= 1'b0;
      errf_q  <= 1'b0;
      proto_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ihl_q   <= ihl_d;
      frag_q  <= frag_d;
      errf_q  <= errf_d;
      proto_q <= proto_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      if (err_inc && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

  fw_tuple_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .tuple_i   (tuple),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .tuple_o   (buf_q),
    .stall_o   (stall)
  );

  assign m_ip_protocol = {buf_q.src_ip, buf_q.dst_ip, buf_q.protocol};
  assign m_src_port    = buf_q.src_port;
  assign m_dst_port    = buf_q.dst_port;
  assign err_count     = err_q;
endmodule

// File: tb/tb_fw_header_parser.sv
// Scoreboard bench: two parsers (with and without non-L4 emission) fed the same accepted words.
module tb_fw_header_parser;
  logic        clk = 1'b0;
  logic        reset, s_valid, s_last, m_ready;
  logic [31:0] s_data;
  logic        s_ready0, s_ready1, mv0, mv1;
  logic [71:0] ip0, ip1;
  logic [15:0] sp0, dp0, sp1, dp1, err0, err1;
  logic        s_valid1;

  always #5 clk = ~clk;
  assign s_valid1 = s_valid && s_ready0;

  fw_header_parser #(.ERR_CNT_W(16), .EMIT_NON_L4(1'b1)) dut0 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready0), .m_ip_protocol(ip0), .m_src_port(sp0), .m_dst_port(dp0),
    .m_valid(mv0), .m_ready(m_ready), .err_count(err0));

  fw_header_parser #(.ERR_CNT_W(16), .EMIT_NON_L4(1'b0)) dut1 (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid1), .s_last(s_last),
    .s_ready(s_ready1), .m_ip_protocol(ip1), .m_src_port(sp1), .m_dst_port(dp1),
    .m_valid(mv1), .m_ready(1'b1), .err_count(err1));

  int checks = 0, errors = 0;
  logic [103:0] q0[$], q1[$];
  logic [32:0]  pkt[$];
  int           st[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] w(input logic [31:0] d);
    return {1'b0, d};
  endfunction
  function automatic logic [32:0] lw(input logic [31:0] d);
    return {1'b1, d};
  endfunction

  // Monitor: pop on every transfer, and require a held tuple to stay put.
  logic [103:0] cur0, cur1, prev0;
  logic         hold0 = 1'b0;
  always @(negedge clk) begin
    if (reset) hold0 = 1'b0;
    else begin
      if (mv0) begin
        cur0 = {ip0, sp0, dp0};
        if (hold0) chk("hold_stable", cur0, prev0);
        if (m_ready) begin
          if (q0.size() == 0) chk("unexpected0", cur0, 0);
          else chk("tuple0", cur0, q0.pop_front());
        end
        hold0 = !m_ready;
        prev0 = cur0;
      end else hold0 = 1'b0;
      if (mv1) begin
        cur1 = {ip1, sp1, dp1};
        if (q1.size() == 0) chk("unexpected1", cur1, 0);
        else chk("tuple1", cur1, q1.pop_front());
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last, output int stalls);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = last; stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); acc = s_ready0;
      @(posedge clk); #1;
      if (acc) break;
      stalls++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_pkt();
    int s;
    st.delete();
    foreach (pkt[i]) begin
      send_word(pkt[i][31:0], pkt[i][32], s);
      st.push_back(s);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_s_ready0", s_ready0, 1); chk("rst_s_ready1", s_ready1, 1);
    chk("rst_m_valid0", mv0, 0);      chk("rst_m_valid1", mv1, 0);
    chk("rst_ip0", ip0, 0);           chk("rst_sp0", sp0, 0);
    chk("rst_dp0", dp0, 0);           chk("rst_err0", err0, 0);
    chk("rst_err1", err1, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset();
    reset = 1'b0;
    idle(2);

    // TCP IHL=5 with latency check around the port word
    q0.push_back({72'hC0A9011E_C0A8011E_06, 16'd16538, 16'd37281});
    q1.push_back({72'hC0A9011E_C0A8011E_06, 16'd16538, 16'd37281});
    send_word(32'h45000028, 1'b0, s); send_word(32'h00004000, 1'b0, s);
    send_word(32'h40060000, 1'b0, s); send_word(32'hC0A9011E, 1'b0, s);
    send_word(32'hC0A8011E, 1'b0, s);
    chk("lat_before0", mv0, 0);
    send_word(32'h409A91A1, 1'b0, s);
    chk("lat_after0", mv0, 1); chk("lat_after1", mv1, 1);
    send_word(32'h00000000, 1'b1, s);
    s_valid = 1'b0; s_last = 1'b0;
    idle(3);

    // UDP IHL=7: ports come from word 7, not the option words
    q0.push_back({72'h0A000001_0A000002_11, 16'h72CA, 16'h97C1});
    q1.push_back({72'h0A000001_0A000002_11, 16'h72CA, 16'h97C1});
    pkt = '{w(32'h47000030), w(32'h00000000), w(32'h40110000), w(32'h0A000001),
            w(32'h0A000002), w(32'hDEADBEEF), w(32'h01020304), w(32'h72CA97C1),
            lw(32'h00000000)};
    send_pkt(); idle(3);

    // ICMP: zero-port tuple only on the emitting parser
    q0.push_back({72'hC0A80001_C0A80002_01, 16'd0, 16'd0});
    pkt = '{w(32'h45000054), w(32'h00004000), w(32'h40010000), w(32'hC0A80001),
            w(32'hC0A80002), w(32'h08000000), lw(32'h00000000)};
    send_pkt(); idle(3);

    // TCP fragment (offset 0x10) is treated as non-L4
    q0.push_back({72'h0B000001_0B000002_06, 16'd0, 16'd0});
    pkt = '{w(32'h45000028), w(32'h00000010), w(32'h40060000), w(32'h0B000001),
            w(32'h0B000002), w(32'h12345678), lw(32'h00000000)};
    send_pkt(); idle(3);

    // Malformed: bad version, short IHL, early last, TCP missing port word
    pkt = '{w(32'h65000028), w(32'h00000000), lw(32'h11111111)};
    send_pkt();
    pkt = '{w(32'h44000028), w(32'h00000000), lw(32'h22222222)};
    send_pkt();
    pkt = '{w(32'h45000028), w(32'h00004000), w(32'h40060000), lw(32'hC0A9011E)};
    send_pkt();
    pkt = '{w(32'h45000028), w(32'h00004000), w(32'h40060000), w(32'hC0A9011E),
            lw(32'hC0A8011E)};
    send_pkt(); idle(3);
    chk("err_count0", err0, 4); chk("err_count1", err1, 4);

    // Backpressure: second packet's port word must stall until the pop
    m_ready = 1'b0;
    q0.push_back({72'hC0A9011E_C0A8011E_06, 16'h409A, 16'h91A1});
    q0.push_back({72'h0A0A0A0A_0B0B0B0B_11, 16'h1111, 16'h2222});
    q1.push_back({72'hC0A9011E_C0A8011E_06, 16'h409A, 16'h91A1});
    q1.push_back({72'h0A0A0A0A_0B0B0B0B_11, 16'h1111, 16'h2222});
    pkt = '{w(32'h45000028), w(32'h00004000), w(32'h40060000), w(32'hC0A9011E),
            w(32'hC0A8011E), w(32'h409A91A1), lw(32'h00000000),
            w(32'h45000028), w(32'h00000000), w(32'h40110000), w(32'h0A0A0A0A),
            w(32'h0B0B0B0B), w(32'h11112222), lw(32'h00000000)};
    fork
      send_pkt();
      begin
        for (int i = 0; i < 200 && !mv0; i++) @(posedge clk);
        if (!mv0) chk("bp_first_tuple", mv0, 1);
        repeat (10) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    foreach (st[i]) chk($sformatf("stall_w%0d", i), st[i] > 0, i == 12);
    idle(4);

    // Reset during word 3 of a packet, then a clean packet
    pkt = '{w(32'h45000028), w(32'h00004000), w(32'h40060000)};
    send_pkt();
    s_valid = 1'b1; s_data = 32'hC0A9011E; s_last = 1'b0;
    @(negedge clk) reset = 1'b1;
    #1 s_valid = 1'b0;
    @(posedge clk); #1 check_reset();
    @(negedge clk) reset = 1'b0;
    idle(2);
    q0.push_back({72'h01020304_05060708_06, 16'h0050, 16'h0BB8});
    q1.push_back({72'h01020304_05060708_06, 16'h0050, 16'h0BB8});
    pkt = '{w(32'h45000028), w(32'h00004000), w(32'h40060000), w(32'h01020304),
            w(32'h05060708), w(32'h00500BB8), lw(32'h00000000)};
    send_pkt(); idle(5);

    chk("q0_drained", q0.size(), 0); chk("q1_drained", q1.size(), 0);
    chk("err_final0", err0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
